// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format codes and RV32I major opcodes.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder, sign-extended to XLEN.
// Optional macro IMM_ZEXT_CSR_EN: CSR*I instructions yield the zero-extended uimm as FMT_Z.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        fmt   = FMT_I;
      end
      OPC_SYSTEM: begin
`ifdef IMM_ZEXT_CSR_EN
        if (inst[14]) begin
          imm32 = {27'd0, inst[19:15]};
          fmt   = FMT_Z;
        end else begin
          imm32 = {{20{inst[31]}}, inst[31:20]};
          fmt   = FMT_I;
        end
`else
        imm32 = {{20{inst[31]}}, inst[31:20]};
        fmt   = FMT_I;
`endif
      end
      OPC_STORE: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {inst[31:12], 12'd0};
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OPC_OP: ;
      default: illegal = 1'b1;
    endcase
  end

  // FMT_Z keeps bit 31 clear, so a single signed widening covers every format.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator: decoder at the input, then a main
// output register M backed by a one-entry skid register K so in_ready_o is registered.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;

  logic             m_valid_reg, k_valid_reg;
  logic [XLEN-1:0]  m_imm_reg, k_imm_reg;
  logic [2:0]       m_fmt_reg, k_fmt_reg;
  logic [TAG_W-1:0] m_tag_reg, k_tag_reg;
  logic             m_ill_reg, k_ill_reg;

  logic accept, m_fire;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (inst_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign in_ready_o = !k_valid_reg && !rst_i;
  assign accept     = in_valid_i && in_ready_o;
  assign m_fire     = m_valid_reg && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_reg <= 1'b0;
      m_imm_reg   <= '0;
      m_fmt_reg   <= FMT_NONE;
      m_tag_reg   <= '0;
      m_ill_reg   <= 1'b0;
      k_valid_reg <= 1'b0;
      k_imm_reg   <= '0;
      k_fmt_reg   <= FMT_NONE;
      k_tag_reg   <= '0;
      k_ill_reg   <= 1'b0;
    end else if (flush_i) begin
      m_valid_reg <= 1'b0;
      k_valid_reg <= 1'b0;
    end else if (!m_valid_reg || m_fire) begin
      // K is always older than a new input; accept cannot coincide with a full K.
      if (k_valid_reg) begin
        m_valid_reg <= 1'b1;
        m_imm_reg   <= k_imm_reg;
        m_fmt_reg   <= k_fmt_reg;
        m_tag_reg   <= k_tag_reg;
        m_ill_reg   <= k_ill_reg;
        k_valid_reg <= 1'b0;
      end else if (accept) begin
        m_valid_reg <= 1'b1;
        m_imm_reg   <= dec_imm;
        m_fmt_reg   <= dec_fmt;
        m_tag_reg   <= tag_i;
        m_ill_reg   <= dec_ill;
      end else begin
        m_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      k_valid_reg <= 1'b1;
      k_imm_reg   <= dec_imm;
      k_fmt_reg   <= dec_fmt;
      k_tag_reg   <= tag_i;
      k_ill_reg   <= dec_ill;
    end
  end

  assign out_valid_o = m_valid_reg;
  assign imm_o       = m_imm_reg;
  assign fmt_o       = m_fmt_reg;
  assign tag_o       = m_tag_reg;
  assign illegal_o   = m_ill_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized + directed bench for imm_gen_pipe against an arithmetic reference model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [31:0]      inst_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       fmt_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .imm_o(imm_o), .fmt_o(fmt_o), .tag_o(tag_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;

  task automatic check(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", t, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] sx(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  // Immediate value from field weights; sign bit carries its negative weight.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [TAG_W-1:0] tg);
    ent_t e;
    longint v = 0;
    longint s = ins[31] ? 1 : 0;
    logic [2:0] f = FMT_NONE;
    logic ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        v = longint'(ins[30:20]) - s * 2048;
        f = FMT_I;
`ifdef IMM_ZEXT_CSR_EN
        if (ins[6:0] == 7'b1110011 && ins[14]) begin
          v = longint'(ins[19:15]);
          f = FMT_Z;
        end
`endif
      end
      7'b0100011: begin
        v = longint'(ins[11:7]) + longint'(ins[30:25]) * 32 - s * 2048;
        f = FMT_S;
      end
      7'b1100011: begin
        v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32 + longint'(ins[7]) * 2048 - s * 4096;
        f = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        v = longint'(ins[30:12]) * 4096 - s * 64'sh8000_0000;
        f = FMT_U;
      end
      7'b1101111: begin
        v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048 + longint'(ins[19:12]) * 4096 - s * 1048576;
        f = FMT_J;
      end
      7'b0110011: ;
      default: ill = 1'b1;
    endcase
    e.imm = XLEN'(v);
    e.fmt = f;
    e.tag = tg;
    e.ill = ill;
    return e;
  endfunction

  // One cycle: drive after negedge, score what the next posedge will do.
  task automatic step(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                      input logic ordy, input logic fl);
    ent_t e;
    @(negedge clk_i);
    in_valid_i = v; inst_i = ins; tag_i = tg; out_ready_i = ordy; flush_i = fl;
    #1;
    check("out_valid", out_valid_o, q.size() > 0);
    check("in_ready", in_ready_o, q.size() < 2);
    if (out_valid_o && out_ready_i && q.size() > 0 && !fl) begin
      e = q.pop_front();
      check("imm", imm_o, e.imm);
      check("fmt", fmt_o, e.fmt);
      check("tag", tag_o, e.tag);
      check("illegal", illegal_o, e.ill);
      $display("out tag=%0d imm=%h fmt=%0d ill=%0d", tag_o, imm_o, fmt_o, illegal_o);
      n_out++;
    end
    if (in_valid_i && in_ready_o && !fl) q.push_back(ref_decode(ins, tg));
    if (fl) q.delete();
  endtask

  task automatic expect_out(input string t, input logic [XLEN-1:0] ei, input logic [2:0] ef);
    @(posedge clk_i);
    #1;
    check({t, "_valid"}, out_valid_o, 1'b1);
    check({t, "_imm"}, imm_o, ei);
    check({t, "_fmt"}, fmt_o, ef);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, '0, 1'b1, 1'b0);
  endtask

  logic [6:0] opcs [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
                            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                            7'b0110011, 7'b1111111};

  initial begin
    logic [31:0] r;
    logic [2:0]  csr_fmt;
    logic [31:0] csr_imm;
    #2;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_imm", imm_o, '0);
    check("rst_fmt", fmt_o, FMT_NONE);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rel_in_ready", in_ready_o, 1'b1);

    // B, U, S, J directed decodes
    step(1'b1, 32'hFE000EE3, 5'd3, 1'b1, 1'b0);
    expect_out("beq", sx(32'hFFFFFFFC), FMT_B);
    step(1'b1, 32'h800000B7, 5'd4, 1'b1, 1'b0);
    expect_out("lui", (XLEN == 64) ? sx(32'h80000000) : XLEN'(32'h80000000), FMT_U);
    step(1'b1, 32'hFE112C23, 5'd5, 1'b1, 1'b0);
    expect_out("sw", sx(32'hFFFFFFF8), FMT_S);
    step(1'b1, 32'h0010006F, 5'd6, 1'b1, 1'b0);
    expect_out("jal", sx(32'h00000800), FMT_J);
    step(1'b1, 32'h0000007F, 5'd7, 1'b1, 1'b0);
    expect_out("bad", '0, FMT_NONE);
    check("bad_illegal", illegal_o, 1'b1);
`ifdef IMM_ZEXT_CSR_EN
    csr_imm = 32'h1; csr_fmt = FMT_Z;
`else
    csr_imm = 32'h5; csr_fmt = FMT_I;
`endif
    step(1'b1, 32'h0050D073, 5'd8, 1'b1, 1'b0);
    expect_out("csrrwi", XLEN'(csr_imm), csr_fmt);
    drain();

    // Backpressure: two accepted, third stalls, then released in order
    step(1'b1, 32'h00100093, 5'd10, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 5'd11, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 5'd12, 1'b0, 1'b0);
    check("bp_in_ready", in_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00300193, 5'd12, 1'b1, 1'b0);
    drain();
    check("bp_empty", q.size(), 0);

    // Flush with M, K full and a same-cycle input
    step(1'b1, 32'h00100093, 5'd13, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 5'd14, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 5'd15, 1'b1, 1'b1);
    step(1'b0, 32'd0, '0, 1'b1, 1'b0);
    check("flush_out_valid", out_valid_o, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom();
      step(($urandom_range(0, 3) != 0), {r[31:7], opcs[$urandom_range(0, 11)]},
           TAG_W'($urandom()), ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end

    // Async reset mid-stream
    step(1'b1, 32'h00100093, 5'd20, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 5'd21, 1'b0, 1'b0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_out_valid", out_valid_o, 1'b0);
    check("arst_in_ready", in_ready_o, 1'b0);
    check("arst_imm", imm_o, '0);
    check("arst_fmt", fmt_o, FMT_NONE);
    check("arst_tag", tag_o, '0);
    check("arst_illegal", illegal_o, 1'b0);
    q.delete();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 32'hFE000EE3, 5'd22, 1'b1, 1'b0);
    drain();
    check("outputs_seen", (n_out > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
